// File: rtl/const_counter.sv
// Parametrised constant / sequence source: holds INIT, loads, clears, or steps
// by STEP inside a [MIN, MAX] window with wrap or saturate at the window edges.
module const_counter #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter logic [WIDTH-1:0] MIN   = '0,
  parameter logic [WIDTH-1:0] MAX   = '1,
  parameter logic [WIDTH:0]   STEP  = {{WIDTH{1'b0}}, 1'b1},
  parameter bit               WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             at_edge,
  output logic             wrapped
);

  typedef struct packed {
    logic             edgeHit;
    logic [WIDTH-1:0] value;
  } stepResult_t;

  // The sum is one bit wider so q + STEP beyond 2^WIDTH-1 cannot alias back into range.
  function automatic stepResult_t stepUp(input logic [WIDTH-1:0] cur);
    stepResult_t    res;
    logic [WIDTH:0] sum;
    sum = {1'b0, cur} + STEP;
    if (sum <= {1'b0, MAX}) begin
      res.edgeHit = 1'b0;
      res.value   = sum[WIDTH-1:0];
    end else begin
      res.edgeHit = 1'b1;
      res.value   = WRAP ? MIN : MAX;
    end
    return res;
  endfunction

  function automatic stepResult_t stepDown(input logic [WIDTH-1:0] cur);
    stepResult_t    res;
    logic [WIDTH:0] floorVal;
    floorVal = {1'b0, MIN} + STEP;
    if ({1'b0, cur} >= floorVal) begin
      res.edgeHit = 1'b0;
      res.value   = cur - STEP[WIDTH-1:0];
    end else begin
      res.edgeHit = 1'b1;
      res.value   = WRAP ? MAX : MIN;
    end
    return res;
  endfunction

  // armed rises on the falling clock edge after reset release, so a release that
  // lands on a rising edge never lets that edge update q.
  logic armed;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  logic [WIDTH-1:0] nextQ;
  logic             nextWrapped;
  stepResult_t      stepRes;

  always_comb begin
    nextQ       = q;
    nextWrapped = 1'b0;
    stepRes     = up ? stepUp(q) : stepDown(q);
    if (clear) begin
      nextQ = INIT;
    end else if (load) begin
      nextQ = d;
    end else if (en) begin
      nextQ       = stepRes.value;
      nextWrapped = stepRes.edgeHit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= INIT;
      wrapped <= 1'b0;
    end else if (armed) begin
      q       <= nextQ;
      wrapped <= nextWrapped;
    end
  end

  assign zero    = (q == '0);
  assign at_edge = up ? (q == MAX) : (q == MIN);

endmodule

// File: tb/tb_const_counter.sv
// Bench for const_counter: six parameter sets share one stimulus bus; directed
// scenarios use constants, the random scenario uses a plain-arithmetic model.
module tb_const_counter;

  localparam int N = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b0;
  logic [31:0] d = '0;

  logic [31:0] q0;
  logic [7:0]  q1, q2, q3, q4;
  logic [3:0]  q5;
  logic [31:0] qv [N];
  logic [N-1:0] zv, ev, wv;

  int checks = 0;
  int errors = 0;

  // Parameter sets of the six instances, as plain integers.
  longint pInit  [N] = '{0, 0, 0, 2, 5, 0};
  longint pMin   [N] = '{0, 0, 0, 2, 10, 0};
  longint pMax   [N] = '{64'hFFFF_FFFF, 9, 9, 9, 250, 15};
  longint pStep  [N] = '{1, 1, 1, 3, 60, 1};
  longint pWrap  [N] = '{1, 1, 0, 0, 1, 1};
  longint pWidth [N] = '{32, 8, 8, 8, 8, 4};

  longint mq [N];
  bit     mw [N];

  always #5 clk = ~clk;

  const_counter u0 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .d(d), .en(en), .up(up),
    .q(q0), .zero(zv[0]), .at_edge(ev[0]), .wrapped(wv[0]));

  const_counter #(.WIDTH(8), .MIN(8'd0), .MAX(8'd9), .STEP(9'd1), .WRAP(1'b1)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .d(d[7:0]), .en(en), .up(up),
    .q(q1), .zero(zv[1]), .at_edge(ev[1]), .wrapped(wv[1]));

  const_counter #(.WIDTH(8), .MIN(8'd0), .MAX(8'd9), .STEP(9'd1), .WRAP(1'b0)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .d(d[7:0]), .en(en), .up(up),
    .q(q2), .zero(zv[2]), .at_edge(ev[2]), .wrapped(wv[2]));

  const_counter #(.WIDTH(8), .INIT(8'd2), .MIN(8'd2), .MAX(8'd9), .STEP(9'd3), .WRAP(1'b0)) u3 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .d(d[7:0]), .en(en), .up(up),
    .q(q3), .zero(zv[3]), .at_edge(ev[3]), .wrapped(wv[3]));

  const_counter #(.WIDTH(8), .INIT(8'd5), .MIN(8'd10), .MAX(8'd250), .STEP(9'd60), .WRAP(1'b1)) u4 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .d(d[7:0]), .en(en), .up(up),
    .q(q4), .zero(zv[4]), .at_edge(ev[4]), .wrapped(wv[4]));

  const_counter #(.WIDTH(4), .MIN(4'd0), .MAX(4'd15), .STEP(5'd1), .WRAP(1'b1)) u5 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .d(d[3:0]), .en(en), .up(up),
    .q(q5), .zero(zv[5]), .at_edge(ev[5]), .wrapped(wv[5]));

  assign qv[0] = q0;
  assign qv[1] = {24'b0, q1};
  assign qv[2] = {24'b0, q2};
  assign qv[3] = {24'b0, q3};
  assign qv[4] = {24'b0, q4};
  assign qv[5] = {28'b0, q5};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: one rising edge, applying the control priority with integer arithmetic.
  task automatic modelEdge();
    for (int i = 0; i < N; i++) begin
      longint span;
      span = longint'(1) << pWidth[i];
      if (clear) begin
        mq[i] = pInit[i];
        mw[i] = 1'b0;
      end else if (load) begin
        mq[i] = {32'b0, d} % span;
        mw[i] = 1'b0;
      end else if (en && up) begin
        if (mq[i] + pStep[i] > pMax[i]) begin
          mq[i] = (pWrap[i] != 0) ? pMin[i] : pMax[i];
          mw[i] = 1'b1;
        end else begin
          mq[i] = mq[i] + pStep[i];
          mw[i] = 1'b0;
        end
      end else if (en) begin
        if (mq[i] - pStep[i] < pMin[i]) begin
          mq[i] = (pWrap[i] != 0) ? pMax[i] : pMin[i];
          mw[i] = 1'b1;
        end else begin
          mq[i] = mq[i] - pStep[i];
          mw[i] = 1'b0;
        end
      end else begin
        mw[i] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (qv[i] !== 32'(pInit[i]) || wv[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: q=%0d wrapped=%b, expected q=%0d wrapped=0", i, qv[i], wv[i], pInit[i]);
      end
    end
    en = 1'b1; up = 1'b1; load = 1'b1; d = 32'd77;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (qv[i] !== 32'(pInit[i]) || wv[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: q=%0d wrapped=%b, expected q=%0d wrapped=0", i, qv[i], wv[i], pInit[i]);
      end
    end
    en = 1'b0; load = 1'b0; up = 1'b0; d = '0;
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default_hold();
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (q0 !== 32'd0 || zv[0] !== 1'b1 || wv[0] !== 1'b0) begin
        errors++;
        $display("FAIL default_hold cycle %0d: q=%0d zero=%b wrapped=%b, expected 0/1/0", k, q0, zv[0], wv[0]);
      end
    end
  endtask

  task automatic test_wrap_up();
    logic [31:0] expQ;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (qv[1] !== 32'd0) begin
      errors++;
      $display("FAIL wrap_up_clear: q=%0d expected 0", qv[1]);
    end
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      expQ = 32'((k + 1) % 10);
      checks++;
      if (qv[1] !== expQ || wv[1] !== (k == 9) || ev[1] !== (expQ == 32'd9)) begin
        errors++;
        $display("FAIL wrap_up edge %0d: q=%0d wrapped=%b at_edge=%b, expected q=%0d wrapped=%b at_edge=%b",
                 k + 1, qv[1], wv[1], ev[1], expQ, (k == 9), (expQ == 32'd9));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    load = 1'b1; d = 32'd8;
    tick();
    load = 1'b0;
    checks++;
    if (qv[2] !== 32'd8) begin
      errors++;
      $display("FAIL sat_load: q=%0d expected 8", qv[2]);
    end
    en = 1'b1; up = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (qv[2] !== 32'd9 || wv[2] !== (k >= 1)) begin
        errors++;
        $display("FAIL sat_up edge %0d: q=%0d wrapped=%b, expected q=9 wrapped=%b", k + 1, qv[2], wv[2], (k >= 1));
      end
    end
    en = 1'b0; load = 1'b1; d = 32'd4;
    tick();
    load = 1'b0;
    checks++;
    if (qv[3] !== 32'd4) begin
      errors++;
      $display("FAIL sat_down_load: q=%0d expected 4", qv[3]);
    end
    en = 1'b1; up = 1'b0;
    tick();
    en = 1'b0;
    checks++;
    if (qv[3] !== 32'd2 || wv[3] !== 1'b1 || ev[3] !== 1'b1) begin
      errors++;
      $display("FAIL sat_down: q=%0d wrapped=%b at_edge=%b, expected q=2 wrapped=1 at_edge=1", qv[3], wv[3], ev[3]);
    end
    tick();
    checks++;
    if (qv[3] !== 32'd2 || wv[3] !== 1'b0) begin
      errors++;
      $display("FAIL sat_pulse_end: q=%0d wrapped=%b, expected q=2 wrapped=0", qv[3], wv[3]);
    end
  endtask

  task automatic test_priority();
    clear = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; d = 32'd200;
    tick();
    checks++;
    if (qv[4] !== 32'd5 || wv[4] !== 1'b0) begin
      errors++;
      $display("FAIL prio_clear: q=%0d wrapped=%b, expected q=5 wrapped=0", qv[4], wv[4]);
    end
    clear = 1'b0; en = 1'b0;
    tick();
    checks++;
    if (qv[4] !== 32'd200) begin
      errors++;
      $display("FAIL prio_load: q=%0d expected 200", qv[4]);
    end
    load = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (qv[4] !== 32'd10 || wv[4] !== 1'b1) begin
      errors++;
      $display("FAIL prio_wrap: q=%0d wrapped=%b, expected q=10 wrapped=1", qv[4], wv[4]);
    end
    load = 1'b1; d = 32'd100;
    tick();
    load = 1'b0; en = 1'b0;
    checks++;
    if (qv[4] !== 32'd100 || wv[4] !== 1'b0) begin
      errors++;
      $display("FAIL prio_load_en: q=%0d wrapped=%b, expected q=100 wrapped=0", qv[4], wv[4]);
    end
  endtask

  task automatic test_midcount_reset();
    clear = 1'b1;
    tick();
    clear = 1'b0; en = 1'b1; up = 1'b1;
    repeat (7) tick();
    checks++;
    if (qv[1] !== 32'd7 || qv[3] !== 32'd9 || wv[3] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_count: q1=%0d q3=%0d wrapped3=%b, expected 7/9/1", qv[1], qv[3], wv[3]);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (qv[1] !== 32'd0 || qv[3] !== 32'd2 || wv[3] !== 1'b0 || wv[1] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: q1=%0d q3=%0d wrapped3=%b, expected 0/2/0", qv[1], qv[3], wv[3]);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (qv[1] !== 32'd0) begin
      errors++;
      $display("FAIL midreset_held: q=%0d expected 0", qv[1]);
    end
    @(posedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (qv[1] !== 32'd0) begin
      errors++;
      $display("FAIL release_edge_ignored: q=%0d expected 0", qv[1]);
    end
    tick();
    en = 1'b0;
    checks++;
    if (qv[1] !== 32'd1) begin
      errors++;
      $display("FAIL release_next_edge: q=%0d expected 1", qv[1]);
    end
  endtask

  task automatic test_w4_wrap();
    load = 1'b1; d = 32'd15;
    tick();
    load = 1'b0; up = 1'b1;
    #1;
    checks++;
    if (qv[5] !== 32'd15 || ev[5] !== 1'b1) begin
      errors++;
      $display("FAIL w4_load: q=%0d at_edge=%b, expected q=15 at_edge=1", qv[5], ev[5]);
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if (qv[5] !== 32'd0 || wv[5] !== 1'b1 || zv[5] !== 1'b1) begin
      errors++;
      $display("FAIL w4_wrap: q=%0d wrapped=%b zero=%b, expected 0/1/1", qv[5], wv[5], zv[5]);
    end
  endtask

  task automatic test_random();
    logic expEdge;
    #1 reset = 1'b0;
    clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; d = '0;
    @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      mq[i] = pInit[i];
      mw[i] = 1'b0;
    end
    @(negedge clk);
    for (int c = 0; c < 400; c++) begin
      clear = ($urandom_range(15) == 0);
      load  = ($urandom_range(7) == 0);
      en    = ($urandom_range(3) != 0);
      up    = 1'($urandom_range(1));
      case ($urandom_range(3))
        0:       d = $urandom;
        1:       d = 32'($urandom_range(15));
        2:       d = 32'($urandom_range(255));
        default: d = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      endcase
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        expEdge = up ? (mq[i] == pMax[i]) : (mq[i] == pMin[i]);
        checks++;
        if (qv[i] !== 32'(mq[i]) || wv[i] !== mw[i] || zv[i] !== (mq[i] == 0) || ev[i] !== expEdge) begin
          errors++;
          $display("FAIL rand[%0d] cycle %0d: q=%0d wrapped=%b zero=%b at_edge=%b, expected q=%0d wrapped=%b zero=%b at_edge=%b",
                   i, c, qv[i], wv[i], zv[i], ev[i], mq[i], mw[i], (mq[i] == 0), expEdge);
        end
      end
    end
    clear = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_hold();
    test_wrap_up();
    test_saturate();
    test_priority();
    test_midcount_reset();
    test_w4_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
